// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start/data/stop
// detection with mid-bit sampling, single-entry hold register with
// acknowledge, framing-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int RATE  = 16,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ticks,
  input  logic             Rx,
  input  logic             Rx_ack,
  output logic [NBITS-1:0] Rx_Data,
  output logic             Rx_valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (RATE > 2) ? $clog2(RATE) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] CNT_HALF  = CW'(RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(RATE - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [BW-1:0]    bidx;
  logic [BW-1:0]    bidx_nx;
  logic [NBITS-1:0] sr;
  logic [NBITS-1:0] sr_nx;
  logic             good_frame;
  logic             bad_frame;

  // Two-stage synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, oversample counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sr    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bidx  <= bidx_nx;
      sr    <= sr_nx;
    end
  end

  // Next-state logic: half-bit start qualification, then full-bit steps so
  // every data and stop sample lands mid-bit.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bidx_nx    = bidx;
    sr_nx      = sr;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (ticks && !rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (ticks) begin
          if (cnt == CNT_HALF) begin
            cnt_nx  = '0;
            bidx_nx = '0;
            if (!rx_s) begin
              state_nx = DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (ticks) begin
          if (cnt == CNT_FULL) begin
            sr_nx   = {rx_s, sr[NBITS-1:1]};
            cnt_nx  = '0;
            bidx_nx = bidx + BW'(1);
            if (bidx == BIDX_LAST) begin
              state_nx = STOP;
            end else begin
              state_nx = DATA;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else begin
          state_nx = DATA;
        end
      end
      STOP: begin
        if (ticks) begin
          if (cnt == CNT_FULL) begin
            // Leave at mid-stop so the next start edge is seen with no dead time.
            state_nx   = IDLE;
            cnt_nx     = '0;
            bidx_nx    = '0;
            good_frame = rx_s;
            bad_frame  = !rx_s;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        bidx_nx  = '0;
      end
    endcase
  end

  // Output hold register: load on good frame, ack clears valid and overrun,
  // a good frame arriving while a byte is still held is dropped as overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rx_Data   <= '0;
      Rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      if (good_frame) begin
        if (!Rx_valid || Rx_ack) begin
          Rx_Data  <= sr;
          Rx_valid <= 1'b1;
          if (Rx_ack) begin
            overrun <= 1'b0;
          end else begin
            overrun <= overrun;
          end
        end else begin
          overrun <= 1'b1;
        end
      end else if (Rx_ack && Rx_valid) begin
        Rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        Rx_valid <= Rx_valid;
        overrun  <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events (received
// byte or framing error) into a queue, a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int RATE   = 16;
  localparam int NBITS  = 8;
  localparam int TDIV   = 4;                     // clocks per tick
  localparam int BITCLK = RATE * TDIV;           // clocks per bit
  localparam int FRMCLK = (NBITS + 2) * BITCLK;  // clocks per frame
  // Clock index (from the first start-bit edge) at which the frame completes:
  // start seen 1 tick later, half-bit qualification, 9 full-bit steps.
  localparam int DONE   = TDIV * (1 + RATE / 2 + (NBITS + 1) * RATE);

  logic             clk = 1'b0;
  logic             rst;
  logic             ticks;
  logic             Rx;
  logic             Rx_ack;
  logic [NBITS-1:0] Rx_Data;
  logic             Rx_valid;
  logic             frame_err;
  logic             overrun;

  logic [1:0] tdiv = 2'd0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic prev_valid = 1'b0;
  logic prev_ack   = 1'b0;

  uart_rx #(.RATE(RATE), .NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .ticks    (ticks),
    .Rx       (Rx),
    .Rx_ack   (Rx_ack),
    .Rx_Data  (Rx_Data),
    .Rx_valid (Rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Tick generator: one tick every TDIV clocks.
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign ticks = (tdiv == 2'd0);

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic compare_event(input logic is_err, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got err=%0b data=%h expected no event at %0t",
               is_err, d, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err !== is_err || (!is_err && e.data !== d)) begin
        n_bad++;
        $display("FAIL event: got err=%0b data=%h expected err=%0b data=%h at %0t",
                 is_err, d, e.is_err, e.data, $time);
      end
    end
  endtask

  // Monitor: a load is Rx_valid rising, or Rx_valid still high right after an ack.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (Rx_valid && (!prev_valid || prev_ack)) compare_event(1'b0, Rx_Data);
        if (frame_err) compare_event(1'b1, 8'h00);
      end
      prev_valid = Rx_valid;
      prev_ack   = Rx_ack;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 Rx_ack = 1'b1;
    @(posedge clk);
    #1 Rx_ack = 1'b0;
  endtask

  // Wait until the next clock edge carries a tick.
  task automatic align_tick();
    do begin
      @(posedge clk);
      #1;
    end while (!ticks);
  endtask

  // Send one frame. rst_at >= 0 aborts it with a reset at that clock index;
  // ack_at_done raises Rx_ack exactly on the frame-completion edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int rst_at, input logic ack_at_done);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    align_tick();
    for (int c = 0; c < FRMCLK; c++) begin
      if (rst_at >= 0 && c >= rst_at) begin
        Rx = 1'b1;
        if (c == rst_at) rst = 1'b0;
        if (c == rst_at + 2) begin
          check("rst_data", Rx_Data, 8'h00);
          check("rst_valid", {7'd0, Rx_valid}, 8'h00);
          check("rst_ferr", {7'd0, frame_err}, 8'h00);
          check("rst_ovr", {7'd0, overrun}, 8'h00);
        end
        if (c == rst_at + 10) begin
          rst = 1'b1;
          break;
        end
      end else if (c % BITCLK == 0) begin
        Rx = fr[c / BITCLK];
      end
      if (ack_at_done) Rx_ack = (c == DONE);
      @(posedge clk);
      #1;
    end
    Rx = 1'b1;
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    Rx     = 1'b1;
    Rx_ack = 1'b0;
    idle(3);
    check("reset_data", Rx_Data, 8'h00);
    check("reset_valid", {7'd0, Rx_valid}, 8'h00);
    check("reset_ferr", {7'd0, frame_err}, 8'h00);
    check("reset_ovr", {7'd0, overrun}, 8'h00);
    rst = 1'b1;
    idle(20);

    // Basic frame and acknowledge.
    push_byte(8'hA5);
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    check("a5_valid", {7'd0, Rx_valid}, 8'h01);
    ack_pulse();
    check("a5_ack_valid", {7'd0, Rx_valid}, 8'h00);
    idle(128);

    // Back-to-back 0x00 then 0xFF, ack overlapping the second frame.
    push_byte(8'h00);
    push_byte(8'hFF);
    send_frame(8'h00, 1'b1, -1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1, -1, 1'b0);
      ack_pulse();
    join
    ack_pulse();
    check("b2b_ovr", {7'd0, overrun}, 8'h00);
    idle(128);

    // Short low glitch is rejected; the next frame still decodes.
    align_tick();
    Rx = 1'b0;
    idle(4 * TDIV);
    Rx = 1'b1;
    idle(128);
    check("glitch_valid", {7'd0, Rx_valid}, 8'h00);
    push_byte(8'h81);
    send_frame(8'h81, 1'b1, -1, 1'b0);
    ack_pulse();
    idle(128);

    // Framing error: stop bit low.
    push_err();
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    check("ferr_valid", {7'd0, Rx_valid}, 8'h00);
    check("ferr_data", Rx_Data, 8'h81);
    idle(128);

    // Overrun: second byte dropped while first is unacknowledged.
    push_byte(8'h11);
    send_frame(8'h11, 1'b1, -1, 1'b0);
    idle(32);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    check("ovr_data", Rx_Data, 8'h11);
    check("ovr_valid", {7'd0, Rx_valid}, 8'h01);
    check("ovr_flag", {7'd0, overrun}, 8'h01);
    ack_pulse();
    check("ovr_ack_valid", {7'd0, Rx_valid}, 8'h00);
    check("ovr_ack_flag", {7'd0, overrun}, 8'h00);
    idle(128);

    // Ack coinciding with completion: new byte loads, no overrun.
    push_byte(8'h11);
    send_frame(8'h11, 1'b1, -1, 1'b0);
    idle(32);
    push_byte(8'h22);
    send_frame(8'h22, 1'b1, -1, 1'b1);
    check("coin_data", Rx_Data, 8'h22);
    check("coin_valid", {7'd0, Rx_valid}, 8'h01);
    check("coin_ovr", {7'd0, overrun}, 8'h00);
    idle(32);

    // Reset during bit 4 of 0x5A, then a clean 0x69.
    send_frame(8'h5A, 1'b1, 5 * BITCLK + BITCLK / 2, 1'b0);
    idle(64);
    push_byte(8'h69);
    send_frame(8'h69, 1'b1, -1, 1'b0);
    check("post_rst_data", Rx_Data, 8'h69);
    check("post_rst_valid", {7'd0, Rx_valid}, 8'h01);
    check("post_rst_ovr", {7'd0, overrun}, 8'h00);
    ack_pulse();
    idle(64);

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter RATE, default 16, ticks per bit period (even, >=4).
REQ-002 Parameter NBITS, default 8, data bits per frame.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 ticks  input  1  oversample enable, one-clk pulse at RATE x baud, synchronous to clk.
REQ-006 Rx  input  1  serial line; idle high; asynchronous to clk.
REQ-007 Rx_ack  input  1  consumer acknowledge of the held byte.
REQ-008 Rx_Data  output  NBITS  last good received byte, LSB-first assembled.
REQ-009 Rx_valid  output  1  level; Rx_Data holds an unacknowledged byte.
REQ-010 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-011 overrun  output  1  sticky; a good frame completed while Rx_valid=1 and no Rx_ack.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer (rx_s, reset value 1) before any use.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; counter cnt and bit index bidx are updated only in clk cycles with ticks=1, except where stated.
REQ-014 IDLE: on tick with rx_s=0 -> START, cnt=0; otherwise stay.
REQ-015 START: on tick, if cnt==RATE/2-1 then rx_s=0 -> DATA (cnt=0, bidx=0), rx_s=1 -> IDLE (glitch rejected, no output); else cnt+1.
REQ-016 DATA: on tick, if cnt==RATE-1: shift register <= {rx_s, sr[NBITS-1:1]}, cnt=0, bidx+1, and if bidx==NBITS-1 -> STOP; else cnt+1.
REQ-017 Sampling point SHALL therefore be mid-bit for every data and stop bit.
REQ-018 STOP: on tick with cnt==RATE-1 -> IDLE in all cases; rx_s=1 = good frame; rx_s=0 = frame_err pulse for that one clk, Rx_Data/Rx_valid unchanged.
REQ-019 Good frame with Rx_valid=0: Rx_Data<=sr, Rx_valid<=1 on the same clk edge.
REQ-020 Rx_ack=1 while Rx_valid=1 SHALL clear Rx_valid on the next edge; Rx_ack while Rx_valid=0 has no effect.
REQ-021 Good frame and Rx_ack in the same cycle: new byte loaded, Rx_valid stays 1, overrun not set.
REQ-022 Good frame while Rx_valid=1 and Rx_ack=0: Rx_Data keeps old byte, new byte dropped, overrun<=1.
REQ-023 overrun SHALL clear on the edge where Rx_ack=1 (ack clears both flags together).
REQ-024 Return to IDLE at mid-stop SHALL allow a following start edge to be detected with no dead time.
REQ-025 Unreachable/illegal state SHALL recover to IDLE with cnt=0, bidx=0.
REQ-026 Rx_ack and ticks SHALL be honoured independently; ack handling does not require a tick.

Reset
REQ-027 rst=0 SHALL immediately force: state=IDLE, cnt=0, bidx=0, sr=0, synchronizer=1s, Rx_Data=0, Rx_valid=0, frame_err=0, overrun=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no valid, error or overrun indication; reception resumes at the next falling edge after rst=1.

Verification
REQ-029 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), RATE=16 -> Rx_Data=0xA5, Rx_valid=1 ~8 ticks into stop bit; Rx_ack -> Rx_valid=0 next clk.
REQ-030 Back-to-back 0x00 then 0xFF, ack after each -> both bytes received, overrun=0, frame_err never asserted.
REQ-031 Rx low for 4 ticks then high -> FSM returns to IDLE at tick 8, no Rx_valid, no frame_err.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err one-clk pulse, Rx_valid stays 0, Rx_Data unchanged.
REQ-033 0x11 unacknowledged then 0x22 -> Rx_Data=0x11, overrun=1; Rx_ack -> Rx_valid=0, overrun=0; repeat with ack coinciding with 0x22 completion -> Rx_Data=0x22, Rx_valid=1, overrun=0.
REQ-034 rst=0 during bit 4 of 0x5A, release, send 0x69 -> all outputs 0 during reset, then Rx_Data=0x69, Rx_valid=1.
